dmem_access_unit: RTL

Sequential data-memory access unit sitting between the single-cycle datapath's load/store control signals and a handshaked external memory bus. It accepts a load or store request, holds the core via a stall line, issues one aligned word transaction with byte enables, and returns sign- or zero-extended load data. It is the responder side of the `data_mem_read_enable` / `data_mem_write_enable` interface, replacing the zero-latency memory model.

---
 rtl/dmem_access_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: handshaked load/store bus master with stall, lane steering and load extension; MISALIGNED_TRAP_EN traps misaligned H/W accesses
module dmem_access_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  inst_funct3,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned_error,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_address,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_byte_enable,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_data
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic        write_q, write_d;
  logic        en, is_b, is_h, legal;
  logic [1:0]  off;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  always_comb begin
    en     = read_enable | write_enable;
    is_b   = inst_funct3[1:0] == 2'b00;
    is_h   = inst_funct3[1:0] == 2'b01;
    off    = address[1:0];
`ifdef MISALIGNED_TRAP_EN
    legal            = !(is_h ? address[0] : (!is_b && address[1:0] != 2'b00));
    misaligned_error = (state_q == IDLE) && en && !legal;
`else
    // Misaligned halves/words are silently realigned to their containing unit.
    legal            = 1'b1;
    misaligned_error = 1'b0;
    off              = is_b ? address[1:0] : is_h ? {address[1], 1'b0} : 2'b00;
`endif
    stall  = ((state_q == IDLE) && en && legal) || state_q == REQ || state_q == WAIT_RESP;
    lane_b = 8'(bus_resp_data >> {addr_q[1:0], 3'b000});
    lane_h = 16'(bus_resp_data >> {addr_q[1], 4'b0000});
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    write_d = write_q;
    case (state_q)
      IDLE: if (en && legal) begin
        addr_d  = {address[31:2], off};
        write_d = write_enable;
        f3_d    = inst_funct3;
        be_d    = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
        wdata_d = is_b ? {4{write_data[7:0]}} : is_h ? {2{write_data[15:0]}} : write_data;
        state_d = REQ;
      end
      REQ: if (bus_req_ready) state_d = write_q ? DONE : WAIT_RESP;
      WAIT_RESP: if (bus_resp_valid) begin
        rdata_d = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane_b[7]}}, lane_b} :
                  f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane_h[15]}}, lane_h} : bus_resp_data;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      write_q <= write_d;
    end
  end
  assign read_data           = rdata_q;
  assign bus_req_valid       = state_q == REQ;
  assign bus_req_write       = write_q;
  assign bus_req_address     = {addr_q[31:2], 2'b00};
  assign bus_req_wdata       = wdata_q;
  assign bus_req_byte_enable = be_q;
endmodule
